// File: rtl/shift_reg_piso_tx.sv
// rtl/shift_reg_piso_tx.sv - parallel-in/serial-out transmitter with sof/eof framing
module shift_reg_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SHIFT) && (cnt == CNT_ZERO);

    // Ready depends only on state, count and strobe so the source never sees a loop through d_valid.
    assign d_ready = !reset && ((state == IDLE) || (last_bit && shift_en));
    assign accept  = d_valid && d_ready;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = d;
                    cnt_nxt   = CNT_MAX;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt != CNT_ZERO) begin
                        shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        cnt_nxt   = cnt - 1'b1;
                    end else if (accept) begin
                        shreg_nxt = d;
                        cnt_nxt   = CNT_MAX;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // All serial-side outputs decode registered state only.
    always_comb begin
        sout_valid = (state == SHIFT);
        busy       = sout_valid;
        sout       = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;
        if (state == SHIFT) begin
            sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            sof  = (cnt == CNT_MAX);
            eof  = (cnt == CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// tb/tb_shift_reg_piso_tx.sv - randomized self-checking bench for shift_reg_piso_tx
module tb_shift_reg_piso_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] d = '0;
    logic         d_valid = 1'b0;
    logic         shift_en = 1'b0;

    logic d_ready_m, sout_m, sout_valid_m, sof_m, eof_m, busy_m;
    logic d_ready_l, sout_l, sout_valid_l, sof_l, eof_l, busy_l;

    always #5 clk = ~clk;

    shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(d_ready_m),
        .shift_en(shift_en), .sout(sout_m), .sout_valid(sout_valid_m),
        .sof(sof_m), .eof(eof_m), .busy(busy_m)
    );

    shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .d_ready(d_ready_l),
        .shift_en(shift_en), .sout(sout_l), .sout_valid(sout_valid_l),
        .sof(sof_l), .eof(eof_l), .busy(busy_l)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a word is "in flight" with the index of the bit currently presented.
    bit           m_busy = 1'b0;
    int           m_pos = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] sent_q[$];
    logic [W-1:0] rx_m = '0;
    logic [W-1:0] rx_l = '0;

    function automatic logic model_bit(input bit msb_first);
        if (!m_busy) return 1'b0;
        return msb_first ? m_word[W-1-m_pos] : m_word[m_pos];
    endfunction

    task automatic step(input bit r, input bit v, input logic [W-1:0] dd, input bit se,
                        output bit acc);
        logic         exp_rdy;
        logic         s_m, s_l;
        logic [W-1:0] exp_word;
        @(negedge clk);
        reset = r; d_valid = v; d = dd; shift_en = se;
        #1;
        exp_rdy = !r && (!m_busy || (m_pos == W-1 && se));
        check_eq("d_ready_m", d_ready_m, exp_rdy);
        check_eq("d_ready_l", d_ready_l, exp_rdy);
        check_eq("sout_valid_m", sout_valid_m, m_busy);
        check_eq("sout_valid_l", sout_valid_l, m_busy);
        check_eq("busy_m", busy_m, m_busy);
        check_eq("sout_m", sout_m, model_bit(1'b1));
        check_eq("sout_l", sout_l, model_bit(1'b0));
        check_eq("sof_m", sof_m, m_busy && m_pos == 0);
        check_eq("eof_m", eof_m, m_busy && m_pos == W-1);
        check_eq("sof_l", sof_l, m_busy && m_pos == 0);
        check_eq("eof_l", eof_l, m_busy && m_pos == W-1);
        s_m = sout_m;
        s_l = sout_l;
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0;
            m_pos  = 0;
            sent_q.delete();
            return;
        end
        // Reassemble the consumed bit stream and compare whole words with what was accepted.
        if (m_busy && se) begin
            rx_m = {rx_m[W-2:0], s_m};
            rx_l = {s_l, rx_l[W-1:1]};
            if (m_pos == W-1) begin
                checks++;
                if (sent_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_q: got empty queue expected a pending word");
                end else begin
                    exp_word = sent_q.pop_front();
                    check_eq("word_m", rx_m, exp_word);
                    check_eq("word_l", rx_l, exp_word);
                end
            end
        end
        if (acc) sent_q.push_back(dd);
        if (!m_busy) begin
            if (acc) begin
                m_busy = 1'b1; m_word = dd; m_pos = 0;
            end
        end else if (se) begin
            if (m_pos < W-1) m_pos++;
            else if (acc) begin
                m_word = dd; m_pos = 0;
            end else m_busy = 1'b0;
        end
    endtask

    logic [W-1:0] bw[2];
    logic [W-1:0] cur;
    bit           acc;
    bit           have;
    int           idx;

    initial begin
        bw[0] = 4'b1011;
        bw[1] = 4'b0110;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, acc);
        step(1'b0, 1'b0, '0, 1'b0, acc);

        step(1'b0, 1'b1, 4'b1011, 1'b1, acc);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

        idx = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, idx < 2, (idx < 2) ? bw[idx] : '0, 1'b1, acc);
            if (acc) idx++;
        end

        have = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, have, 4'b1100, (i % 2) == 0, acc);
            if (acc) have = 1'b0;
        end

        have = 1'b1;
        idx = 0;
        for (int i = 0; i < 8 && idx < 2; i++) begin
            step(1'b0, have, 4'b1111, 1'b1, acc);
            if (acc) have = 1'b0;
            else if (!have) idx++;
        end
        step(1'b1, 1'b1, 4'b1111, 1'b1, acc);
        have = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, have, 4'b0001, 1'b1, acc);
            if (acc) have = 1'b0;
        end

        have = 1'b0;
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!have && ($urandom_range(0, 3) != 0)) begin
                have = 1'b1;
                cur  = W'($urandom);
            end
            step($urandom_range(0, 99) == 0, have, have ? cur : W'($urandom),
                 $urandom_range(0, 9) < 7, acc);
            if (acc || reset) have = 1'b0;
        end

        for (int i = 0; i < 2 * W + 2; i++) step(1'b0, 1'b0, '0, 1'b1, acc);
        check_eq("queue_drained", sent_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
